ika9958_regwr: RTL

- CPU-side writer for the VDP register file: decodes Z80 port writes on ports #1 (control), #2 (palette) and #3 (indirect register) and owns the 64x8 register array.
- The register array drives the register interface `arr` field, replacing the constant register assignments.
- Also emits VRAM address-setup strobes and palette write strobes to the VRAM and palette blocks.

---
 rtl/ika9958_regwr.sv | 79 +++++++
 1 files changed

// File: rtl/ika9958_regwr.sv
// ika9958_regwr: CPU port-write decoder owning the VDP 64x8 register file, VRAM address setup and palette writes
module ika9958_regwr (
  input  logic             i_EMUCLK,
  input  logic             i_RST_n,
  input  logic             i_WR,
  input  logic             i_RD,
  input  logic [1:0]       i_MODE,
  input  logic [7:0]       i_DB,
  output logic [63:0][7:0] o_REG,
  output logic             o_REGWR_STB,
  output logic [5:0]       o_REGWR_NUM,
  output logic             o_VADDR_STB,
  output logic [13:0]      o_VADDR,
  output logic             o_VADDR_WR,
  output logic             o_PAL_WE,
  output logic [3:0]       o_PAL_ADDR,
  output logic [8:0]       o_PAL_DATA
);
  logic       phase, pphase;
  logic [7:0] latch;
  logic [2:0] pal_r, pal_b;
  logic       wr1, wr2, wr3, rd1, reg_wr, vaddr_wr;
  logic [5:0] reg_num;
  logic [7:0] reg_val;
  always_comb begin
    wr1 = i_WR && i_MODE == 2'd1;
    wr2 = i_WR && i_MODE == 2'd2;
    wr3 = i_WR && i_MODE == 2'd3;
    rd1 = i_RD && !i_WR && i_MODE == 2'd1;
    reg_num = wr3 ? o_REG[17][5:0] : i_DB[5:0];
    reg_val = wr3 ? i_DB : latch;
    reg_wr = (wr3 || (wr1 && phase && i_DB[7])) && reg_num != 6'd24 && reg_num < 6'd47 && !(wr3 && reg_num == 6'd17);
    vaddr_wr = wr1 && phase && !i_DB[7];
  end
  always_ff @(posedge i_EMUCLK or negedge i_RST_n)
    if (!i_RST_n) begin
      o_REG <= '0;
      phase <= 1'b0;
      pphase <= 1'b0;
      latch <= '0;
      pal_r <= '0;
      pal_b <= '0;
      o_REGWR_STB <= 1'b0;
      o_REGWR_NUM <= '0;
      o_VADDR_STB <= 1'b0;
      o_VADDR <= '0;
      o_VADDR_WR <= 1'b0;
      o_PAL_WE <= 1'b0;
      o_PAL_ADDR <= '0;
      o_PAL_DATA <= '0;
    end else begin
      o_REGWR_STB <= reg_wr;
      o_VADDR_STB <= vaddr_wr;
      o_PAL_WE <= wr2 && pphase;
      if (reg_wr) begin
        o_REG[reg_num] <= reg_val;
        o_REGWR_NUM <= reg_num;
      end
      if (wr3 && !o_REG[17][7]) o_REG[17][5:0] <= o_REG[17][5:0] + 6'd1;
      if (wr1) phase <= !phase;
      else if (rd1) phase <= 1'b0;
      if (wr1 && !phase) latch <= i_DB;
      if (vaddr_wr) begin
        o_VADDR <= {i_DB[5:0], latch};
        o_VADDR_WR <= i_DB[6];
      end
      if (wr2) pphase <= !pphase;
      if (wr2 && !pphase) begin
        pal_r <= i_DB[6:4];
        pal_b <= i_DB[2:0];
      end
      if (wr2 && pphase) begin
        o_PAL_ADDR <= o_REG[16][3:0];
        o_PAL_DATA <= {pal_r, i_DB[2:0], pal_b};
        o_REG[16] <= {4'd0, o_REG[16][3:0] + 4'd1};
      end
      if (reg_wr && reg_num == 6'd16) pphase <= 1'b0;
    end
endmodule
